// File: rtl/card_dealer_if.sv
// Handshake bundle between a card_dealer and whatever loads and draws from it.
// The controller drives the master side and the dealer sits on the slave side.
interface card_dealer_if #(
    parameter int unsigned CARD_W     = 6,
    parameter int unsigned DECK_DEPTH = 52
);
    localparam int unsigned CNT_W = $clog2(DECK_DEPTH + 1);

    logic              load_valid;
    logic [CARD_W-1:0] load_card;
    logic              load_done;
    logic              req;
    logic              rewind;
    logic [15:0]       seed;
    logic              load_ready;
    logic              card_valid;
    logic [CARD_W-1:0] card;
    logic [CNT_W-1:0]  remaining;
    logic              empty;
    logic              busy;
    logic              err;

    modport master (
        output load_valid, load_card, load_done, req, rewind, seed,
        input  load_ready, card_valid, card, remaining, empty, busy, err
    );

    modport slave (
        input  load_valid, load_card, load_done, req, rewind, seed,
        output load_ready, card_valid, card, remaining, empty, busy, err
    );
endinterface

// File: rtl/card_dealer.sv
// Card dealer: load a deck, optionally shuffle it (macro CARD_SHUFFLE_EN),
// then deal one card per request with rewind support.
module card_dealer #(
    parameter int unsigned CARD_W     = 6,
    parameter int unsigned DECK_DEPTH = 52
) (
    input  logic         clk,
    input  logic         reset,
    card_dealer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DECK_DEPTH + 1);
    localparam int unsigned IDX_W = (DECK_DEPTH > 1) ? $clog2(DECK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DECK_DEPTH);

`ifdef CARD_SHUFFLE_EN
    typedef enum logic [1:0] {StLoad, StShuffle, StReady} state_e;
`else
    typedef enum logic [1:0] {StLoad, StReady} state_e;
`endif

    logic [CARD_W-1:0] r_mem [DECK_DEPTH];

    state_e            r_state, w_state_d;
    logic [CNT_W-1:0]  r_count, w_count_d;
    logic [CNT_W-1:0]  r_ptr, w_ptr_d;
    logic [CNT_W-1:0]  r_remaining, w_remaining_d;
    logic [CARD_W-1:0] r_card, w_card_d;
    logic              r_card_valid, w_card_valid_d;
    logic              r_err, w_err_d;
    logic              w_load_ready;
    logic              w_load_we;

`ifdef CARD_SHUFFLE_EN
    logic [15:0]       r_lfsr, w_lfsr_d;
    logic [CNT_W-1:0]  r_i, w_i_d;
    logic              w_swap_en;
    logic [IDX_W-1:0]  w_swap_i;
    logic [IDX_W-1:0]  w_swap_j;
    logic              w_fb;

    // x^16 + x^14 + x^13 + x^11 + 1
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_swap_i = r_i[IDX_W-1:0];
    assign w_swap_j = IDX_W'(r_lfsr % 16'(r_i + CNT_W'(1)));
`else
    logic w_unused_seed;
    assign w_unused_seed = ^bus.seed;
`endif

    assign w_load_ready = (r_state == StLoad) && (r_count < DEPTH_C);

    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_ptr_d        = r_ptr;
        w_remaining_d  = r_remaining;
        w_card_d       = r_card;
        w_card_valid_d = 1'b0;
        w_err_d        = r_err;
        w_load_we      = 1'b0;
`ifdef CARD_SHUFFLE_EN
        w_lfsr_d       = r_lfsr;
        w_i_d          = r_i;
        w_swap_en      = 1'b0;
`endif
        case (r_state)
            StLoad: begin
                if (bus.load_valid) begin
                    if ((bus.load_card == '0) || !w_load_ready) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_load_we = 1'b1;
                        w_count_d = r_count + CNT_W'(1);
                    end
                end
                // A card accepted alongside load_done is already in w_count_d.
                if (bus.load_done) begin
                    w_ptr_d       = '0;
                    w_remaining_d = w_count_d;
`ifdef CARD_SHUFFLE_EN
                    w_state_d = StShuffle;
                    w_lfsr_d  = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
                    w_i_d     = (w_count_d == '0) ? '0 : w_count_d - CNT_W'(1);
`else
                    w_state_d = StReady;
`endif
                end
            end
`ifdef CARD_SHUFFLE_EN
            StShuffle: begin
                w_swap_en = (r_i != '0);
                w_lfsr_d  = {r_lfsr[14:0], w_fb};
                if (r_i <= CNT_W'(1)) begin
                    w_state_d = StReady;
                end else begin
                    w_i_d = r_i - CNT_W'(1);
                end
            end
`endif
            StReady: begin
                if (bus.rewind) begin
                    w_ptr_d       = '0;
                    w_remaining_d = r_count;
                end else if (bus.req) begin
                    if (r_remaining != '0) begin
                        w_card_d       = r_mem[r_ptr[IDX_W-1:0]];
                        w_card_valid_d = 1'b1;
                        w_ptr_d        = r_ptr + CNT_W'(1);
                        w_remaining_d  = r_remaining - CNT_W'(1);
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            default: w_state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StLoad;
            r_count      <= '0;
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_card       <= '0;
            r_card_valid <= 1'b0;
            r_err        <= 1'b0;
`ifdef CARD_SHUFFLE_EN
            r_lfsr       <= 16'hACE1;
            r_i          <= '0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_ptr        <= w_ptr_d;
            r_remaining  <= w_remaining_d;
            r_card       <= w_card_d;
            r_card_valid <= w_card_valid_d;
            r_err        <= w_err_d;
`ifdef CARD_SHUFFLE_EN
            r_lfsr       <= w_lfsr_d;
            r_i          <= w_i_d;
`endif
        end
    end

    // Deck storage is never cleared; count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem[r_count[IDX_W-1:0]] <= bus.load_card;
        end
`ifdef CARD_SHUFFLE_EN
        if (w_swap_en) begin
            r_mem[w_swap_i] <= r_mem[w_swap_j];
            r_mem[w_swap_j] <= r_mem[w_swap_i];
        end
`endif
    end

    assign bus.load_ready = w_load_ready;
    assign bus.card_valid = r_card_valid;
    assign bus.card       = r_card;
    assign bus.remaining  = r_remaining;
    assign bus.empty      = (r_state == StReady) && (r_remaining == '0);
`ifdef CARD_SHUFFLE_EN
    assign bus.busy       = (r_state == StShuffle);
`else
    assign bus.busy       = 1'b0;
`endif
    assign bus.err        = r_err;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a 52-deep and a 4-deep instance share clock and reset.
module tb_card_dealer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [15:0] SEED = 16'h1234;
`ifdef CARD_SHUFFLE_EN
    localparam int EXP_BUSY = 9;
`else
    localparam int EXP_BUSY = 0;
`endif

    logic [5:0] exp_q [52];
    int         exp_n = 0;

    card_dealer_if #(.CARD_W(6), .DECK_DEPTH(52)) bus ();
    card_dealer_if #(.CARD_W(6), .DECK_DEPTH(4))  bus4 ();

    card_dealer #(.CARD_W(6), .DECK_DEPTH(52)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    card_dealer #(.CARD_W(6), .DECK_DEPTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Reference order: loaded order, Fisher-Yates permuted when shuffling is built in.
    task automatic build_exp();
`ifdef CARD_SHUFFLE_EN
        logic [15:0] l;
        logic [5:0]  t;
        int          j;
        l = SEED;
        for (int i = exp_n - 1; i >= 1; i--) begin
            j = int'(l % 16'(i + 1));
            t = exp_q[i];
            exp_q[i] = exp_q[j];
            exp_q[j] = t;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
`endif
    endtask

    task automatic clear_inputs();
        bus.load_valid = 1'b0;  bus.load_card = '0;  bus.load_done = 1'b0;
        bus.req = 1'b0;  bus.rewind = 1'b0;  bus.seed = SEED;
        bus4.load_valid = 1'b0; bus4.load_card = '0; bus4.load_done = 1'b0;
        bus4.req = 1'b0; bus4.rewind = 1'b0; bus4.seed = SEED;
    endtask

    task automatic apply_reset();
        clear_inputs();
        exp_n = 0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic push(input logic [5:0] v, input bit four);
        if (four) begin
            bus4.load_valid = 1'b1; bus4.load_card = v;
        end else begin
            bus.load_valid = 1'b1;  bus.load_card = v;
        end
        if (v != 6'd0 && exp_n < (four ? 4 : 52)) begin
            exp_q[exp_n] = v;
            exp_n++;
        end
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        bus4.load_valid = 1'b0;
    endtask

    task automatic finish_load(input bit four, output int n);
        if (four) bus4.load_done = 1'b1;
        else      bus.load_done = 1'b1;
        @(posedge clk); #1;
        bus.load_done = 1'b0;
        bus4.load_done = 1'b0;
        n = 0;
        while ((bus.busy || bus4.busy) && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (bus.busy || bus4.busy) begin
            errors++;
            $display("FAIL shuffle_timeout: busy still %b/%b after %0d cycles, required 0",
                     bus.busy, bus4.busy, n);
        end
        build_exp();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #2;
        checks += 7;
        if (bus.load_ready !== 1'b1) begin errors++;
            $display("FAIL rst_load_ready: got %b required 1", bus.load_ready); end
        if (bus.card_valid !== 1'b0) begin errors++;
            $display("FAIL rst_card_valid: got %b required 0", bus.card_valid); end
        if (bus.card !== 6'd0) begin errors++;
            $display("FAIL rst_card: got %0d required 0", bus.card); end
        if (bus.remaining !== 6'd0) begin errors++;
            $display("FAIL rst_remaining: got %0d required 0", bus.remaining); end
        if (bus.empty !== 1'b0) begin errors++;
            $display("FAIL rst_empty: got %b required 0", bus.empty); end
        if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b required 0", bus.busy); end
        if (bus.err !== 1'b0) begin errors++;
            $display("FAIL rst_err: got %b required 0", bus.err); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_deal_basic();
        int n;
        apply_reset();
        push(6'd10, 1'b0); push(6'd8, 1'b0); push(6'd4, 1'b0);
        finish_load(1'b0, n);
        for (int k = 0; k < 3; k++) begin
            bus.req = 1'b1;
            @(posedge clk); #1;
            bus.req = 1'b0;
            checks += 3;
            if (bus.card_valid !== 1'b1) begin errors++;
                $display("FAIL basic_valid[%0d]: got %b required 1", k, bus.card_valid); end
            if (bus.card !== exp_q[k]) begin errors++;
                $display("FAIL basic_card[%0d]: got %0d required %0d", k, bus.card, exp_q[k]); end
            if (32'(bus.remaining) !== 2 - k) begin errors++;
                $display("FAIL basic_remaining[%0d]: got %0d required %0d", k, bus.remaining,
                         2 - k); end
            @(posedge clk); #1;
            checks++;
            if (bus.card_valid !== 1'b0) begin errors++;
                $display("FAIL basic_idle_valid[%0d]: got %b required 0", k, bus.card_valid); end
        end
        checks += 2;
        if (bus.empty !== 1'b1) begin errors++;
            $display("FAIL basic_empty: got %b required 1", bus.empty); end
        if (bus.err !== 1'b0) begin errors++;
            $display("FAIL basic_err_early: got %b required 0", bus.err); end
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        checks += 3;
        if (bus.card_valid !== 1'b0) begin errors++;
            $display("FAIL empty_req_valid: got %b required 0", bus.card_valid); end
        if (bus.err !== 1'b1) begin errors++;
            $display("FAIL empty_req_err: got %b required 1", bus.err); end
        if (bus.card !== exp_q[2]) begin errors++;
            $display("FAIL empty_req_card: got %0d required %0d", bus.card, exp_q[2]); end
    endtask

    task automatic test_rewind();
        int n;
        apply_reset();
        push(6'd10, 1'b0); push(6'd10, 1'b0); push(6'd8, 1'b0);
        push(6'd4, 1'b0);  push(6'd8, 1'b0);  push(6'd2, 1'b0);
        finish_load(1'b0, n);
        bus.req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks += 3;
            if (bus.card_valid !== 1'b1) begin errors++;
                $display("FAIL b2b_valid[%0d]: got %b required 1", k, bus.card_valid); end
            if (bus.card !== exp_q[k]) begin errors++;
                $display("FAIL b2b_card[%0d]: got %0d required %0d", k, bus.card, exp_q[k]); end
            if (32'(bus.remaining) !== 5 - k) begin errors++;
                $display("FAIL b2b_remaining[%0d]: got %0d required %0d", k, bus.remaining,
                         5 - k); end
        end
        bus.rewind = 1'b1;
        @(posedge clk); #1;
        bus.rewind = 1'b0;
        checks += 2;
        if (bus.card_valid !== 1'b0) begin errors++;
            $display("FAIL rewind_valid: got %b required 0", bus.card_valid); end
        if (bus.remaining !== 6'd6) begin errors++;
            $display("FAIL rewind_remaining: got %0d required 6", bus.remaining); end
        @(posedge clk); #1;
        bus.req = 1'b0;
        checks += 3;
        if (bus.card_valid !== 1'b1) begin errors++;
            $display("FAIL rewind_next_valid: got %b required 1", bus.card_valid); end
        if (bus.card !== exp_q[0]) begin errors++;
            $display("FAIL rewind_next_card: got %0d required %0d", bus.card, exp_q[0]); end
        if (bus.err !== 1'b0) begin errors++;
            $display("FAIL rewind_err: got %b required 0", bus.err); end
    endtask

    task automatic test_overflow();
        int n;
        apply_reset();
        push(6'd3, 1'b1); push(6'd7, 1'b1); push(6'd9, 1'b1); push(6'd1, 1'b1);
        checks += 2;
        if (bus4.load_ready !== 1'b0) begin errors++;
            $display("FAIL full_load_ready: got %b required 0", bus4.load_ready); end
        if (bus4.err !== 1'b0) begin errors++;
            $display("FAIL full_err_early: got %b required 0", bus4.err); end
        push(6'd6, 1'b1);
        checks++;
        if (bus4.err !== 1'b1) begin errors++;
            $display("FAIL overflow_err: got %b required 1", bus4.err); end
        finish_load(1'b1, n);
        checks++;
        if (bus4.remaining !== 3'd4) begin errors++;
            $display("FAIL overflow_remaining: got %0d required 4", bus4.remaining); end
        bus4.req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks += 2;
            if (bus4.card_valid !== 1'b1) begin errors++;
                $display("FAIL small_valid[%0d]: got %b required 1", k, bus4.card_valid); end
            if (bus4.card !== exp_q[k]) begin errors++;
                $display("FAIL small_card[%0d]: got %0d required %0d", k, bus4.card, exp_q[k]);
            end
        end
        @(posedge clk); #1;
        bus4.req = 1'b0;
        checks += 2;
        if (bus4.card_valid !== 1'b0) begin errors++;
            $display("FAIL small_fifth_valid: got %b required 0", bus4.card_valid); end
        if (bus4.empty !== 1'b1) begin errors++;
            $display("FAIL small_empty: got %b required 1", bus4.empty); end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        for (int v = 2; v < 7; v++) push(6'(v), 1'b0);
        finish_load(1'b0, n);
        bus.req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        checks += 5;
        if (bus.card_valid !== 1'b0) begin errors++;
            $display("FAIL arst_valid: got %b required 0", bus.card_valid); end
        if (bus.card !== 6'd0) begin errors++;
            $display("FAIL arst_card: got %0d required 0", bus.card); end
        if (bus.remaining !== 6'd0) begin errors++;
            $display("FAIL arst_remaining: got %0d required 0", bus.remaining); end
        if (bus.load_ready !== 1'b1) begin errors++;
            $display("FAIL arst_load_ready: got %b required 1", bus.load_ready); end
        if (bus.empty !== 1'b0) begin errors++;
            $display("FAIL arst_empty: got %b required 0", bus.empty); end
        bus.req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_n = 0;
        finish_load(1'b0, n);
        checks += 2;
        if (bus.remaining !== 6'd0) begin errors++;
            $display("FAIL arst_count_cleared: got %0d required 0", bus.remaining); end
        if (bus.empty !== 1'b1) begin errors++;
            $display("FAIL arst_empty_after: got %b required 1", bus.empty); end
    endtask

    task automatic test_zero_card();
        int n;
        apply_reset();
        push(6'd5, 1'b0);
        checks++;
        if (bus.err !== 1'b0) begin errors++;
            $display("FAIL zero_err_early: got %b required 0", bus.err); end
        push(6'd0, 1'b0);
        checks += 2;
        if (bus.err !== 1'b1) begin errors++;
            $display("FAIL zero_err: got %b required 1", bus.err); end
        if (bus.load_ready !== 1'b1) begin errors++;
            $display("FAIL zero_load_ready: got %b required 1", bus.load_ready); end
        push(6'd9, 1'b0);
        finish_load(1'b0, n);
        checks++;
        if (bus.remaining !== 6'd2) begin errors++;
            $display("FAIL zero_remaining: got %0d required 2", bus.remaining); end
        bus.load_valid = 1'b1; bus.load_card = 6'd3; bus.load_done = 1'b1;
        @(posedge clk); #1;
        bus.load_valid = 1'b0; bus.load_done = 1'b0;
        checks++;
        if (bus.remaining !== 6'd2) begin errors++;
            $display("FAIL ready_load_ignored: got %0d required 2", bus.remaining); end
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        checks++;
        if (bus.card !== exp_q[0]) begin errors++;
            $display("FAIL zero_first_card: got %0d required %0d", bus.card, exp_q[0]); end
    endtask

    task automatic test_order();
        int          n;
        logic [63:0] mask;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            for (int v = 2; v < 12; v++) push(6'(v), 1'b0);
            finish_load(1'b0, n);
            checks++;
            if (n !== EXP_BUSY) begin errors++;
                $display("FAIL busy_cycles[%0d]: got %0d required %0d", pass, n, EXP_BUSY); end
            mask = '0;
            bus.req = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                mask[bus.card] = 1'b1;
                checks++;
                if (bus.card_valid !== 1'b1 || bus.card !== exp_q[k]) begin errors++;
                    $display("FAIL order[%0d][%0d]: got %0d (valid %b) required %0d", pass, k,
                             bus.card, bus.card_valid, exp_q[k]); end
            end
            bus.req = 1'b0;
            checks += 2;
            if (mask !== 64'hFFC) begin errors++;
                $display("FAIL multiset[%0d]: got %h required %h", pass, mask, 64'hFFC); end
            if (bus.empty !== 1'b1) begin errors++;
                $display("FAIL order_empty[%0d]: got %b required 1", pass, bus.empty); end
        end
    endtask

    initial begin
        test_reset();
        test_deal_basic();
        test_rewind();
        test_overflow();
        test_async_reset();
        test_zero_card();
        test_order();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
